// File: rtl/modexp_ctrl.sv
// modexp_ctrl
// Computes o_result = i_base ^ i_exponent mod i_modulus with left-to-right
// binary square-and-multiply. It drives one external modular multiplier
// (barrett_mult) through its operand buses and an en/valid handshake. Only one
// multiply is ever outstanding, and the operands stay constant while it runs.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       asynchronous, active-high reset
//   i_start     1-cycle request, only honoured while idle
//   i_base      base operand, captured on an accepted start (caller keeps < modulus)
//   i_exponent  exponent, captured on an accepted start
//   i_modulus   modulus, captured on an accepted start (caller keeps >= 1)
//   o_busy      high from the cycle after an accepted start until done
//   o_done      1-cycle pulse; o_result is valid from this cycle
//   o_result    final value, held until the next completed operation
//   o_mm_en     1-cycle pulse launching one multiply
//   o_mm_a      multiplier operand a
//   o_mm_b      multiplier operand b
//   o_mm_n      multiplier modulus (the captured modulus)
//   i_mm_r      multiplier product, valid when i_mm_valid is high
//   i_mm_valid  1-cycle pulse marking i_mm_r valid, latency >= 1 after o_mm_en
module modexp_ctrl #(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_base,
  input  logic [EXP_WIDTH-1:0] i_exponent,
  input  logic [WIDTH-1:0]     i_modulus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_result,
  output logic                 o_mm_en,
  output logic [WIDTH-1:0]     o_mm_a,
  output logic [WIDTH-1:0]     o_mm_b,
  output logic [WIDTH-1:0]     o_mm_n,
  input  logic [WIDTH-1:0]     i_mm_r,
  input  logic                 i_mm_valid
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_SQR_REQ  = 3'd2,
    S_SQR_WAIT = 3'd3,
    S_MUL_REQ  = 3'd4,
    S_MUL_WAIT = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_base;
  logic [WIDTH-1:0]     r_mod;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_mmA;
  logic [WIDTH-1:0]     r_mmB;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_mmEn;

  logic w_expBit;
  logic w_idxZero;

  assign w_expBit  = r_exp[r_idx];
  assign w_idxZero = (r_idx == '0);

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_mm_en  = r_mmEn;
  assign o_mm_a   = r_mmA;
  assign o_mm_b   = r_mmB;
  assign o_mm_n   = r_mod;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_mod    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_mmA    <= '0;
      r_mmB    <= '0;
      r_exp    <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mmEn   <= 1'b0;
    end else begin
      // done and mm_en are single-cycle pulses unless a state re-asserts them
      r_done <= 1'b0;
      r_mmEn <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base  <= i_base;
            r_exp   <= i_exponent;
            r_mod   <= i_modulus;
            r_idx   <= IDX_MAX;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end

        // Walk down past leading zeros; the first set bit seeds acc with base,
        // so the top bit never needs a square or a multiply.
        S_SCAN: begin
          if (w_expBit) begin
            r_acc <= r_base;
            if (w_idxZero) begin
              r_state <= S_FIN;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_SQR_REQ;
            end
          end else if (w_idxZero) begin
            // x^0 is 1, except that 1 mod 1 is 0
            r_acc   <= (r_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_state <= S_FIN;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end

        S_SQR_REQ: begin
          r_mmA   <= r_acc;
          r_mmB   <= r_acc;
          r_mmEn  <= 1'b1;
          r_state <= S_SQR_WAIT;
        end

        // idx still points at the bit whose square just completed
        S_SQR_WAIT: begin
          if (i_mm_valid) begin
            r_acc <= i_mm_r;
            if (w_expBit) begin
              r_state <= S_MUL_REQ;
            end else if (!w_idxZero) begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_SQR_REQ;
            end else begin
              r_state <= S_FIN;
            end
          end
        end

        S_MUL_REQ: begin
          r_mmA   <= r_acc;
          r_mmB   <= r_base;
          r_mmEn  <= 1'b1;
          r_state <= S_MUL_WAIT;
        end

        S_MUL_WAIT: begin
          if (i_mm_valid) begin
            r_acc <= i_mm_r;
            if (w_idxZero) begin
              r_state <= S_FIN;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_SQR_REQ;
            end
          end
        end

        // start is not sampled here; a request in this cycle is dropped
        S_FIN: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl
// Scoreboard bench for modexp_ctrl. The stimulus process pushes the expected
// result and multiply count for every accepted start. A behavioural modular
// multiplier answers each mm_en after a random 1-8 cycle latency. A monitor
// process checks reset values, the handshake, and each done against the queue.
module tb_modexp_ctrl;

  localparam int W  = 256;
  localparam int EW = 256;
  localparam logic [W-1:0] SECP =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic          clock;
  logic          reset;
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exponent;
  logic [W-1:0]  modulus;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          mmEn;
  logic [W-1:0]  mmA;
  logic [W-1:0]  mmB;
  logic [W-1:0]  mmN;
  logic [W-1:0]  mmR;
  logic          mmValid;

  typedef struct {
    logic [W-1:0] res;
    int           mulCount;
  } expect_t;

  expect_t expQ[$];

  int    checkCount  = 0;
  int    passCount   = 0;
  int    doneCount   = 0;
  int    waitSeq     = 0;
  int    waitSeqSeen = 0;
  bit    waitOk      = 1'b0;
  string waitName    = "";
  bit    endReq      = 1'b0;
  bit    endSeen     = 1'b0;
  int    forceLat    = 0;
  bit    modelBusy   = 1'b0;

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_start    (start),
    .i_base     (base),
    .i_exponent (exponent),
    .i_modulus  (modulus),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_mm_en    (mmEn),
    .o_mm_a     (mmA),
    .o_mm_b     (mmB),
    .o_mm_n     (mmN),
    .i_mm_r     (mmR),
    .i_mm_valid (mmValid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Plain-arithmetic reference: full double-width product, then remainder
  function automatic logic [W-1:0] mulMod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, n};
    return p[W-1:0];
  endfunction

  // Right-to-left exponentiation, deliberately unlike the DUT's ordering
  function automatic logic [W-1:0] powMod(input logic [W-1:0] b, input logic [EW-1:0] e,
                                          input logic [W-1:0] n);
    logic [W-1:0] r;
    logic [W-1:0] sq;
    r  = (n == W'(1)) ? '0 : W'(1);
    sq = b;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = mulMod(r, sq, n);
      sq = mulMod(sq, sq, n);
    end
    return r;
  endfunction

  // (bit length - 1) squares plus (popcount - 1) multiplies; none for e == 0
  function automatic int mulCountOf(input logic [EW-1:0] e);
    int msb;
    msb = -1;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) msb = i;
    end
    if (msb < 0) return 0;
    return msb + $countones(e) - 1;
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checkCount++;
    if (act === req) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Behavioural multiplier: answers each mm_en after a random latency
  logic [W-1:0] modelA;
  logic [W-1:0] modelB;
  logic [W-1:0] modelN;
  int           modelLat;

  initial begin
    mmValid = 1'b0;
    mmR     = '0;
    forever begin
      @(negedge clock);
      if (mmEn && !reset) begin
        modelA    = mmA;
        modelB    = mmB;
        modelN    = mmN;
        modelLat  = (forceLat != 0) ? forceLat : int'($urandom_range(1, 8));
        modelBusy = 1'b1;
        repeat (modelLat) @(posedge clock);
        #1;
        mmR     = mulMod(modelA, modelB, modelN);
        mmValid = 1'b1;
        @(posedge clock);
        #1;
        mmValid   = 1'b0;
        mmR       = rand256();
        modelBusy = 1'b0;
      end
    end
  end

  // Monitor: the only process that compares and steps the counters
  logic [W-1:0] capA;
  logic [W-1:0] capB;
  logic [W-1:0] capN;
  bit           outstanding = 1'b0;
  int           enCount     = 0;
  expect_t      popped;

  always @(negedge clock) begin
    if (reset) begin
      checkOutput("rstBusy",   W'(busy),   '0);
      checkOutput("rstDone",   W'(done),   '0);
      checkOutput("rstMmEn",   W'(mmEn),   '0);
      checkOutput("rstResult", result,     '0);
      checkOutput("rstMmA",    mmA,        '0);
      checkOutput("rstMmB",    mmB,        '0);
      checkOutput("rstMmN",    mmN,        '0);
      outstanding = 1'b0;
      enCount     = 0;
    end else begin
      if (mmEn) begin
        enCount++;
        checkOutput("oneOutstanding", W'(outstanding), '0);
        outstanding = 1'b1;
        capA = mmA;
        capB = mmB;
        capN = mmN;
      end else if (mmValid && outstanding) begin
        checkOutput("stableA", mmA, capA);
        checkOutput("stableB", mmB, capB);
        checkOutput("stableN", mmN, capN);
        outstanding = 1'b0;
      end
      if (done) begin
        checkOutput("expectPending", W'(expQ.size() > 0), W'(1));
        if (expQ.size() > 0) begin
          popped = expQ.pop_front();
          checkOutput("result",     result,       popped.res);
          checkOutput("mmCount",    W'(enCount),  W'(popped.mulCount));
          checkOutput("busyAtDone", W'(busy),     '0);
        end
        enCount = 0;
        doneCount++;
      end
    end
    if (waitSeq != waitSeqSeen) begin
      waitSeqSeen = waitSeq;
      checkOutput(waitName, W'(waitOk), W'(1));
    end
    if (endReq && !endSeen) begin
      endSeen = 1'b1;
      checkOutput("queueEmpty", W'(expQ.size()), '0);
    end
  end

  task automatic reportWait(input string name, input bit ok);
    waitName = name;
    waitOk   = ok;
    waitSeq++;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [W-1:0] b, input logic [EW-1:0] e,
                               input logic [W-1:0] n, input logic [W-1:0] res,
                               input int cnt, input bit push);
    @(posedge clock);
    #1;
    base     = b;
    exponent = e;
    modulus  = n;
    start    = 1'b1;
    if (push) expQ.push_back('{res: res, mulCount: cnt});
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (doneCount < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    reportWait(name, doneCount >= target);
  endtask

  task automatic waitEn(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!mmEn && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!mmEn) reportWait(name, 1'b0);
  endtask

  int           doneTarget;
  logic [W-1:0] rn;
  logic [W-1:0] rb;
  logic [EW-1:0] re;

  initial begin
    doneTarget = 0;
    reset      = 1'b1;
    start      = 1'b0;
    base       = '0;
    exponent   = '0;
    modulus    = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Fixed vectors with hand-derived answers
    applyStimulus(W'(4), EW'(13), W'(497), W'(445), 5, 1'b1);
    doneTarget++; waitDone(doneTarget, 3000, "doneBasic");
    applyStimulus(W'(2), EW'(96), W'(97), W'(1), 7, 1'b1);
    doneTarget++; waitDone(doneTarget, 3000, "doneFermat");
    applyStimulus(W'(3), EW'(0), W'(13), W'(1), 0, 1'b1);
    doneTarget++; waitDone(doneTarget, 3000, "doneExpZero");
    applyStimulus(W'(0), EW'(0), W'(1), W'(0), 0, 1'b1);
    doneTarget++; waitDone(doneTarget, 3000, "doneModOne");
    applyStimulus(W'(5), EW'(1), W'(13), W'(5), 0, 1'b1);
    doneTarget++; waitDone(doneTarget, 3000, "doneExpOne");

    // A second start while busy must not disturb the running operation
    applyStimulus(W'(4), EW'(13), W'(497), W'(445), 5, 1'b1);
    waitEn(3000, "enBeforeRestart");
    applyStimulus(W'(7), EW'(5), W'(11), W'(0), 0, 1'b0);
    doneTarget++; waitDone(doneTarget, 3000, "doneIgnoreStart");

    // Reset during the first square, with start raised alongside it; the
    // multiplier answers long after reset and that answer must be ignored
    forceLat = 8;
    applyStimulus(W'(4), EW'(13), W'(497), W'(0), 0, 1'b0);
    waitEn(3000, "enBeforeReset");
    #1;
    reset    = 1'b1;
    start    = 1'b1;
    base     = W'(9);
    exponent = EW'(3);
    modulus  = W'(23);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    start    = 1'b0;
    forceLat = 0;
    begin
      int n;
      n = 0;
      while (modelBusy && n < 50) begin
        @(negedge clock);
        n++;
      end
      reportWait("staleDrained", !modelBusy);
    end
    repeat (5) @(posedge clock);
    applyStimulus(W'(4), EW'(13), W'(497), W'(445), 5, 1'b1);
    doneTarget++; waitDone(doneTarget, 3000, "doneAfterReset");

    // Randomised operands against the reference model
    for (int t = 0; t < 12; t++) begin
      rn = rand256() >> $urandom_range(0, W - 2);
      if (rn == '0) rn = W'(1);
      rb = rand256() % rn;
      re = rand256() >> (EW - int'($urandom_range(0, 20)));
      applyStimulus(rb, re, rn, powMod(rb, re, rn), mulCountOf(re), 1'b1);
      doneTarget++; waitDone(doneTarget, 3000, "doneRandom");
    end

    // (n-1)^odd = n-1, exercising every square and multiply
    applyStimulus(SECP - W'(1), '1, SECP, SECP - W'(1), 510, 1'b1);
    doneTarget++; waitDone(doneTarget, 10000, "doneSecp");

    endReq = 1'b1;
    repeat (3) @(negedge clock);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
